// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial sequence detector.
//   seq_det_state_t : detector FSM encoding
//   len_width()     : width of a field holding 0..max_len
//   len_mask()      : low-order mask with 'len' ones (len 0..32)
package seq_det_pkg;

   typedef enum logic [1:0] {
      S_UNCFG = 2'd0,
      S_HUNT  = 2'd1,
      S_DET   = 2'd2
   } seq_det_state_t;

   function automatic int len_width(input int max_len);
      return $clog2(max_len + 1);
   endfunction

   function automatic logic [31:0] len_mask(input logic [5:0] len);
      if (len >= 6'd32) begin
         return '1;
      end
      return (32'd1 << len) - 32'd1;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i   : clock, rising edge
//   rst_n_i : synchronous active-low reset, counter -> 0
//   inc_i   : increment request (ignored once at all-ones)
//   clr_i   : synchronous clear, wins over inc_i
//   cnt_o   : current count
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_det_prog.sv
// Runtime-programmable serial sequence detector (Moore output).
//   clk_i         : clock, rising edge
//   rst_n_i       : synchronous active-low reset (clears configuration too)
//   cfg_load_i    : strobe capturing cfg_pattern_i / cfg_len_i / cfg_overlap_i
//   cfg_pattern_i : pattern, first bit received = bit [len-1]
//   cfg_len_i     : pattern length, legal 1..MAX_LEN
//   cfg_overlap_i : 1 = overlapping matches, 0 = flush fill after a match
//   valid_i       : qualifies data_i
//   data_i        : serial data bit
//   clr_cnt_i     : synchronous clear of the match counter
//   seq_det_o     : one-cycle pulse the cycle after the accepting bit
//   match_cnt_o   : saturating match count
//   cfg_err_o     : one-cycle pulse after a rejected load
//   armed_o       : a legal configuration is loaded
module seq_det_prog
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 16,
   parameter int LEN_W   = len_width(MAX_LEN)
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               cfg_load_i,
   input  logic [MAX_LEN-1:0] cfg_pattern_i,
   input  logic [LEN_W-1:0]   cfg_len_i,
   input  logic               cfg_overlap_i,
   input  logic               valid_i,
   input  logic               data_i,
   input  logic               clr_cnt_i,
   output logic               seq_det_o,
   output logic [CNT_W-1:0]   match_cnt_o,
   output logic               cfg_err_o,
   output logic               armed_o
);

   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

   seq_det_state_t     state_q, state_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   // Only MAX_LEN-1 past bits are needed: the current bit completes the window.
   logic [MAX_LEN-2:0] hist_q, hist_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic               ovl_q, ovl_d;
   logic               err_q, err_d;

   logic [MAX_LEN-1:0] window;
   logic [MAX_LEN-1:0] mask;
   logic [LEN_W:0]     fill_inc;   // one extra bit so len = MAX_LEN never wraps
   logic               armed;
   logic               cfg_legal;
   logic               accept;
   logic               match_hit;

   assign armed     = (state_q != S_UNCFG);
   assign cfg_legal = (cfg_len_i != '0) && (cfg_len_i <= MAX_LEN_L);
   // A load in the same cycle swallows the data bit.
   assign accept    = armed && valid_i && !cfg_load_i;
   assign window    = {hist_q, data_i};
   assign mask      = MAX_LEN'(len_mask(6'(len_q)));
   assign fill_inc  = {1'b0, fill_q} + (LEN_W+1)'(1);
   assign match_hit = accept
                    && (fill_inc >= {1'b0, len_q})
                    && (((window ^ pat_q) & mask) == '0);

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      hist_d  = hist_q;
      len_d   = len_q;
      fill_d  = fill_q;
      ovl_d   = ovl_q;
      err_d   = 1'b0;

      // The match pulse is a single cycle regardless of what else happens.
      if (state_q == S_DET) begin
         state_d = S_HUNT;
      end

      if (cfg_load_i) begin
         if (cfg_legal) begin
            pat_d   = cfg_pattern_i;
            len_d   = cfg_len_i;
            ovl_d   = cfg_overlap_i;
            hist_d  = '0;
            fill_d  = '0;
            state_d = S_HUNT;
         end else begin
            err_d = 1'b1;
         end
      end else if (accept) begin
         hist_d = window[MAX_LEN-2:0];
         fill_d = (fill_inc >= {1'b0, len_q}) ? len_q : fill_inc[LEN_W-1:0];
         if (match_hit) begin
            state_d = S_DET;
            if (!ovl_q) begin
               fill_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= S_UNCFG;
         pat_q   <= '0;
         hist_q  <= '0;
         len_q   <= '0;
         fill_q  <= '0;
         ovl_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         hist_q  <= hist_d;
         len_q   <= len_d;
         fill_q  <= fill_d;
         ovl_q   <= ovl_d;
         err_q   <= err_d;
      end
   end

   sat_counter #(
      .W(CNT_W)
   ) u_match_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .inc_i   (match_hit),
      .clr_i   (clr_cnt_i),
      .cnt_o   (match_cnt_o)
   );

   assign seq_det_o = (state_q == S_DET);
   assign cfg_err_o = err_q;
   assign armed_o   = armed;

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed bench for seq_det_prog. Two instances share all stimulus: one with
// the default 16-bit counter, one with a 2-bit counter for saturation checks.
module tb_seq_det_prog;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, cfg_load, cfg_ovl, valid, data, clr;
   logic [7:0] cfg_pat;
   logic [3:0] cfg_len;

   logic        det_a, err_a, armed_a;
   logic [15:0] cnt_a;
   logic        det_b, err_b, armed_b;
   logic [1:0]  cnt_b;

   int total = 0;
   int bad   = 0;

   // expected-count model and armed expectation
   logic [15:0] ea;
   logic [1:0]  eb;
   logic        ex_armed;

   typedef struct packed {
      logic        det;
      logic [15:0] ca;
      logic [1:0]  cb;
      logic        armed;
      logic        err;
   } exp_t;
   exp_t sb[$];

   seq_det_prog #(.MAX_LEN(8), .CNT_W(16)) dut_a (
      .clk_i(clk), .rst_n_i(rst_n), .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pat),
      .cfg_len_i(cfg_len), .cfg_overlap_i(cfg_ovl), .valid_i(valid), .data_i(data),
      .clr_cnt_i(clr), .seq_det_o(det_a), .match_cnt_o(cnt_a), .cfg_err_o(err_a),
      .armed_o(armed_a)
   );

   seq_det_prog #(.MAX_LEN(8), .CNT_W(2)) dut_b (
      .clk_i(clk), .rst_n_i(rst_n), .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pat),
      .cfg_len_i(cfg_len), .cfg_overlap_i(cfg_ovl), .valid_i(valid), .data_i(data),
      .clr_cnt_i(clr), .seq_det_o(det_b), .match_cnt_o(cnt_b), .cfg_err_o(err_b),
      .armed_o(armed_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Push the expectation for the edge about to happen, then pop and compare.
   task automatic edge_and_check(input logic exp_det, input logic exp_err);
      exp_t e;
      e.det   = exp_det;
      e.ca    = ea;
      e.cb    = eb;
      e.armed = ex_armed;
      e.err   = exp_err;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      $display("t=%0t v=%0b d=%0b load=%0b clr=%0b det=%0b cnt_a=%0d cnt_b=%0d armed=%0b err=%0b",
               $time, valid, data, cfg_load, clr, det_a, cnt_a, cnt_b, armed_a, err_a);
      chk("det_a",   32'(det_a),   32'(e.det));
      chk("det_b",   32'(det_b),   32'(e.det));
      chk("cnt_a",   32'(cnt_a),   32'(e.ca));
      chk("cnt_b",   32'(cnt_b),   32'(e.cb));
      chk("armed_a", 32'(armed_a), 32'(e.armed));
      chk("armed_b", 32'(armed_b), 32'(e.armed));
      chk("err_a",   32'(err_a),   32'(e.err));
      chk("err_b",   32'(err_b),   32'(e.err));
   endtask

   task automatic step(input logic v, input logic d, input logic exp_det, input logic c);
      valid = v;
      data  = d;
      clr   = c;
      if (c) begin
         ea = '0;
         eb = '0;
      end else if (exp_det) begin
         if (ea != 16'hFFFF) ea = ea + 16'd1;
         if (eb != 2'b11)    eb = eb + 2'd1;
      end
      edge_and_check(exp_det, 1'b0);
      valid = 1'b0;
      clr   = 1'b0;
   endtask

   task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o, input logic legal);
      cfg_load = 1'b1;
      cfg_pat  = p;
      cfg_len  = l;
      cfg_ovl  = o;
      if (legal) ex_armed = 1'b1;
      edge_and_check(1'b0, !legal);
      cfg_load = 1'b0;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      ea       = '0;
      eb       = '0;
      ex_armed = 1'b0;
      edge_and_check(1'b0, 1'b0);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] p;
      rst_n = 1'b0; cfg_load = 1'b0; cfg_pat = '0; cfg_len = '0; cfg_ovl = 1'b0;
      valid = 1'b0; data = 1'b0; clr = 1'b0;
      ea = '0; eb = '0; ex_armed = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // unconfigured: bits ignored
      step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
      // illegal loads before any legal one
      load(8'hFF, 4'd0, 1'b1, 1'b0);
      load(8'hFF, 4'd9, 1'b1, 1'b0);

      // 101 overlapping, then a rejected load must keep the configuration
      load(8'h05, 4'd3, 1'b1, 1'b1);
      load(8'h00, 4'd0, 1'b0, 1'b0);
      step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 1, 0);
      step(1, 0, 0, 0); step(1, 1, 1, 0); step(0, 0, 0, 0);

      // 101 non-overlapping; high pattern bits are don't-care
      step(0, 0, 0, 1);
      load(8'hE5, 4'd3, 1'b0, 1'b1);
      step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 1, 0);
      step(1, 0, 0, 0); step(1, 1, 0, 0);
      step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 1, 0);

      // length 1: back-to-back pulses, gaps hold
      step(0, 0, 0, 1);
      load(8'h01, 4'd1, 1'b1, 1'b1);
      step(1, 1, 1, 0); step(1, 1, 1, 0); step(1, 1, 1, 0);
      step(0, 0, 0, 0); step(1, 0, 0, 0); step(0, 1, 0, 0); step(1, 1, 1, 0);

      // 101 with gaps carrying junk data
      load(8'h05, 4'd3, 1'b1, 1'b1);
      step(1, 1, 0, 0); step(0, 1, 0, 0); step(0, 0, 0, 0);
      step(1, 0, 0, 0); step(0, 1, 0, 0); step(1, 1, 1, 0);

      // saturation on the 2-bit counter, then clear on a match cycle
      step(0, 0, 0, 1);
      load(8'hA5, 4'd8, 1'b0, 1'b1);
      p = 8'hA5;
      for (int r = 0; r < 5; r++) begin
         for (int i = 7; i >= 0; i--) begin
            step(1, p[i], (i == 0), 0);
         end
      end
      for (int i = 7; i >= 1; i--) begin
         step(1, p[i], 0, 0);
      end
      step(1, p[0], 1, 1);

      // reset mid-pattern drops configuration
      load(8'h05, 4'd3, 1'b1, 1'b1);
      step(1, 1, 0, 0); step(1, 0, 0, 0);
      do_reset();
      step(1, 1, 0, 0);

      // reload mid-pattern flushes history; load also swallows a valid bit
      load(8'h05, 4'd3, 1'b1, 1'b1);
      step(1, 1, 0, 0); step(1, 0, 0, 0);
      valid = 1'b1;
      data  = 1'b1;
      load(8'h05, 4'd3, 1'b1, 1'b1);
      valid = 1'b0;
      step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 1, 0);
      step(0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
